// File: rtl/cci_mpf_active_req_tracker_pkg.sv
// Shared configuration, types and the saturating count update for the active request tracker.
package cci_mpf_active_req_pkg;

  localparam int unsigned N_CHANNELS_DFLT        = 2;
  localparam int unsigned MAX_ACTIVE_REQS        = 1024;
  localparam int unsigned MAX_LINES_PER_REQ      = 4;
  localparam int unsigned ALMOST_FULL_SLACK_DFLT = 64;

  localparam int unsigned LW = $clog2(MAX_LINES_PER_REQ + 1);
  localparam int unsigned CW = $clog2(MAX_ACTIVE_REQS) + 1;
  // Sum width: holds cnt + lines - lines without wrap, top bit acts as sign.
  localparam int unsigned SW = CW + LW + 1;

  typedef logic [CW-1:0] t_active_cnt;
  typedef logic [LW-1:0] t_req_lines;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } t_drain_state;

  typedef struct packed {
    t_active_cnt cnt;
    logic        overflow;
    logic        underflow;
  } t_cnt_update;

  // Effective line count of one event: 0 when disabled, a 0 field counts as 1.
  function automatic t_req_lines eff_lines(input logic en, input t_req_lines lines);
    if (!en)             return '0;
    else if (lines == '0) return LW'(1);
    else                 return lines;
  endfunction

  // Next count with clamp at 0 and at all-ones, flagging which bound was hit.
  function automatic t_cnt_update sat_update(input t_active_cnt cnt,
                                             input logic        incr_en,
                                             input t_req_lines  incr_lines,
                                             input logic        decr_en,
                                             input t_req_lines  decr_lines);
    t_cnt_update upd;
    logic [SW-1:0] v_next;
    upd    = '0;
    v_next = SW'(cnt) + SW'(eff_lines(incr_en, incr_lines))
           - SW'(eff_lines(decr_en, decr_lines));
    if (v_next[SW-1]) begin
      upd.cnt       = '0;
      upd.underflow = 1'b1;
    end else if (|v_next[SW-2:CW]) begin
      upd.cnt      = '1;
      upd.overflow = 1'b1;
    end else begin
      upd.cnt = v_next[CW-1:0];
    end
    return upd;
  endfunction

endpackage

// File: rtl/cci_mpf_active_req_tracker_if.sv
// Bundle of per-channel request/response events, drain handshake and status.
interface cci_mpf_active_req_tracker_if
  import cci_mpf_active_req_pkg::*;
#(
  parameter int unsigned N_CHANNELS = N_CHANNELS_DFLT
) ();

  logic [N_CHANNELS-1:0]    incrEn;
  logic [N_CHANNELS*LW-1:0] incrLines;
  logic [N_CHANNELS-1:0]    decrEn;
  logic [N_CHANNELS*LW-1:0] decrLines;
  logic                     drainReq;
  logic                     blockNew;
  logic                     drainAck;
  logic [N_CHANNELS-1:0]    notEmpty;
  logic [N_CHANNELS-1:0]    almostFull;
  logic [N_CHANNELS*CW-1:0] activeCnt;
  logic [N_CHANNELS-1:0]    errOverflow;
  logic [N_CHANNELS-1:0]    errUnderflow;

  // AFU / MPF side that generates traffic
  modport master (
    output incrEn, incrLines, decrEn, decrLines, drainReq,
    input  blockNew, drainAck, notEmpty, almostFull, activeCnt,
           errOverflow, errUnderflow
  );

  // Tracker side
  modport slave (
    input  incrEn, incrLines, decrEn, decrLines, drainReq,
    output blockNew, drainAck, notEmpty, almostFull, activeCnt,
           errOverflow, errUnderflow
  );

endinterface

// File: rtl/cci_mpf_active_req_tracker_counter.sv
// Single-channel in-flight line counter with registered flags and sticky errors.
module cci_mpf_active_req_counter
  import cci_mpf_active_req_pkg::*;
#(
  parameter int unsigned AF_THRESH = MAX_ACTIVE_REQS - ALMOST_FULL_SLACK_DFLT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_incr_en,
  input  t_req_lines  i_incr_lines,
  input  logic        i_decr_en,
  input  t_req_lines  i_decr_lines,
  output t_active_cnt o_cnt,
  output logic        o_not_empty,
  output logic        o_almost_full,
  output logic        o_err_overflow,
  output logic        o_err_underflow
);

  t_cnt_update w_upd;
  t_active_cnt r_cnt;
  logic        r_not_empty;
  logic        r_almost_full;
  logic        r_err_overflow;
  logic        r_err_underflow;

  // Combined increment/decrement for this cycle
  always_comb begin
    w_upd = sat_update(r_cnt, i_incr_en, i_incr_lines, i_decr_en, i_decr_lines);
  end

  // Count and flags are registered from the same next value, so they move together
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt           <= '0;
      r_not_empty     <= 1'b0;
      r_almost_full   <= 1'b0;
      r_err_overflow  <= 1'b0;
      r_err_underflow <= 1'b0;
    end else begin
      r_cnt           <= w_upd.cnt;
      r_not_empty     <= (w_upd.cnt != '0);
      r_almost_full   <= (w_upd.cnt >= CW'(AF_THRESH));
      r_err_overflow  <= r_err_overflow  | w_upd.overflow;
      r_err_underflow <= r_err_underflow | w_upd.underflow;
    end
  end

  assign o_cnt           = r_cnt;
  assign o_not_empty     = r_not_empty;
  assign o_almost_full   = r_almost_full;
  assign o_err_overflow  = r_err_overflow;
  assign o_err_underflow = r_err_underflow;

endmodule

// File: rtl/cci_mpf_active_req_tracker.sv
// N-channel active request tracker: per-channel counters plus the drain handshake FSM.
module cci_mpf_active_req_tracker
  import cci_mpf_active_req_pkg::*;
#(
  parameter int unsigned N_CHANNELS        = N_CHANNELS_DFLT,
  parameter int unsigned ALMOST_FULL_SLACK = ALMOST_FULL_SLACK_DFLT
) (
  input logic                         clk,
  input logic                         reset_n,
  cci_mpf_active_req_tracker_if.slave bus
);

  logic [N_CHANNELS-1:0] w_not_empty;
  logic                  w_all_empty;
  logic                  w_incr_any;
  t_drain_state          r_state;
  t_drain_state          w_state_nxt;
  logic                  w_block_new_nxt;
  logic                  w_drain_ack_nxt;
  logic                  r_block_new;
  logic                  r_drain_ack;

  for (genvar g = 0; g < N_CHANNELS; g++) begin : g_chan
    cci_mpf_active_req_counter #(
      .AF_THRESH (MAX_ACTIVE_REQS - ALMOST_FULL_SLACK)
    ) u_counter (
      .clk             (clk),
      .reset_n         (reset_n),
      .i_incr_en       (bus.incrEn[g]),
      .i_incr_lines    (bus.incrLines[g*LW +: LW]),
      .i_decr_en       (bus.decrEn[g]),
      .i_decr_lines    (bus.decrLines[g*LW +: LW]),
      .o_cnt           (bus.activeCnt[g*CW +: CW]),
      .o_not_empty     (w_not_empty[g]),
      .o_almost_full   (bus.almostFull[g]),
      .o_err_overflow  (bus.errOverflow[g]),
      .o_err_underflow (bus.errUnderflow[g])
    );
  end

  // Quiescence is judged on registered counts; a same-cycle increment vetoes it
  assign w_all_empty = &(~w_not_empty);
  assign w_incr_any  = |bus.incrEn;

  // Drain FSM next state and next output values
  always_comb begin
    w_state_nxt     = r_state;
    w_block_new_nxt = 1'b0;
    w_drain_ack_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.drainReq) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!bus.drainReq)                   w_state_nxt = IDLE;
        else if (w_all_empty && !w_incr_any) w_state_nxt = DONE;
      end
      DONE: begin
        if (!bus.drainReq)   w_state_nxt = IDLE;
        else if (w_incr_any) w_state_nxt = DRAIN;
      end
      default: w_state_nxt = IDLE;
    endcase
    w_block_new_nxt = (w_state_nxt != IDLE);
    w_drain_ack_nxt = (w_state_nxt == DONE);
  end

  // State and handshake outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_block_new <= 1'b0;
      r_drain_ack <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_block_new <= w_block_new_nxt;
      r_drain_ack <= w_drain_ack_nxt;
    end
  end

  assign bus.notEmpty = w_not_empty;
  assign bus.blockNew = r_block_new;
  assign bus.drainAck = r_drain_ack;

endmodule

// File: tb/tb_cci_mpf_active_req_tracker.sv
// Directed, table-driven bench for the active request tracker (2 channels, defaults).
module tb_cci_mpf_active_req_tracker;
  import cci_mpf_active_req_pkg::*;

  localparam int unsigned NCH    = 2;
  localparam int unsigned AF_LVL = 960;
  localparam int unsigned NVEC   = 20;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_bad;

  cci_mpf_active_req_tracker_if #(.N_CHANNELS(NCH)) bus ();

  cci_mpf_active_req_tracker #(
    .N_CHANNELS        (NCH),
    .ALMOST_FULL_SLACK (64)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] ie;
    logic [2:0] il0;
    logic [2:0] il1;
    logic [1:0] de;
    logic [2:0] dl0;
    logic [2:0] dl1;
    logic       drain;
    int         c0;
    int         c1;
    logic [1:0] ovf;
    logic [1:0] unf;
    logic       bn;
    logic       da;
  } vec_t;

  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] ie, input logic [2:0] il0, input logic [2:0] il1,
                       input logic [1:0] de, input logic [2:0] dl0, input logic [2:0] dl1,
                       input logic drain);
    bus.incrEn    = ie;
    bus.incrLines = {il1, il0};
    bus.decrEn    = de;
    bus.decrLines = {dl1, dl0};
    bus.drainReq  = drain;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int c0, input int c1,
                           input logic [1:0] ovf, input logic [1:0] unf,
                           input logic bn, input logic da);
    logic [1:0] ne;
    logic [1:0] af;
    ne = {c1 != 0, c0 != 0};
    af = {c1 >= int'(AF_LVL), c0 >= int'(AF_LVL)};
    check({tag, " cnt0"},   32'(bus.activeCnt[CW-1:0]),    32'(c0));
    check({tag, " cnt1"},   32'(bus.activeCnt[2*CW-1:CW]), 32'(c1));
    check({tag, " nempty"}, 32'(bus.notEmpty),             32'(ne));
    check({tag, " afull"},  32'(bus.almostFull),           32'(af));
    check({tag, " ovf"},    32'(bus.errOverflow),          32'(ovf));
    check({tag, " unf"},    32'(bus.errUnderflow),         32'(unf));
    check({tag, " block"},  32'(bus.blockNew),             32'(bn));
    check({tag, " ack"},    32'(bus.drainAck),             32'(da));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    //          ie    il0 il1 de    dl0 dl1 drn c0 c1 ovf   unf   bn da
    vecs[0]  = '{2'b01, 4, 0, 2'b00, 0, 0, 0, 4, 0, 2'b00, 2'b00, 0, 0};
    vecs[1]  = '{2'b00, 0, 0, 2'b01, 4, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0};
    vecs[2]  = '{2'b10, 0, 4, 2'b00, 0, 0, 0, 0, 4, 2'b00, 2'b00, 0, 0};
    vecs[3]  = '{2'b10, 3, 0, 2'b00, 0, 0, 0, 0, 5, 2'b00, 2'b00, 0, 0};
    vecs[4]  = '{2'b10, 0, 3, 2'b10, 0, 1, 0, 0, 7, 2'b00, 2'b00, 0, 0};
    vecs[5]  = '{2'b10, 0, 2, 2'b10, 0, 2, 0, 0, 7, 2'b00, 2'b00, 0, 0};
    vecs[6]  = '{2'b01, 3, 0, 2'b00, 0, 7, 0, 3, 7, 2'b00, 2'b00, 0, 0};
    vecs[7]  = '{2'b00, 0, 0, 2'b10, 0, 4, 0, 3, 3, 2'b00, 2'b00, 0, 0};
    vecs[8]  = '{2'b00, 0, 0, 2'b10, 0, 3, 1, 3, 0, 2'b00, 2'b00, 1, 0};
    vecs[9]  = '{2'b00, 0, 0, 2'b01, 3, 0, 1, 0, 0, 2'b00, 2'b00, 1, 0};
    vecs[10] = '{2'b00, 0, 0, 2'b00, 0, 0, 1, 0, 0, 2'b00, 2'b00, 1, 1};
    vecs[11] = '{2'b01, 1, 0, 2'b00, 0, 0, 1, 1, 0, 2'b00, 2'b00, 1, 0};
    vecs[12] = '{2'b00, 0, 0, 2'b01, 1, 0, 1, 0, 0, 2'b00, 2'b00, 1, 0};
    vecs[13] = '{2'b00, 0, 0, 2'b00, 0, 0, 1, 0, 0, 2'b00, 2'b00, 1, 1};
    vecs[14] = '{2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0};
    vecs[15] = '{2'b00, 0, 0, 2'b00, 0, 0, 1, 0, 0, 2'b00, 2'b00, 1, 0};
    vecs[16] = '{2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0};
    vecs[17] = '{2'b01, 1, 0, 2'b00, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0};
    vecs[18] = '{2'b00, 0, 0, 2'b01, 2, 0, 0, 0, 0, 2'b00, 2'b01, 0, 0};
    vecs[19] = '{2'b01, 2, 0, 2'b00, 0, 0, 0, 2, 0, 2'b00, 2'b01, 0, 0};

    // Reset, released between clock edges
    reset_n = 1'b0;
    drive(2'b00, 0, 0, 2'b00, 0, 0, 1'b0);
    #12;
    check_all("reset", 0, 0, 2'b00, 2'b00, 1'b0, 1'b0);
    reset_n = 1'b1;

    // Table: one cycle per vector, outputs checked just after the edge
    for (int i = 0; i < int'(NVEC); i++) begin
      drive(vecs[i].ie, vecs[i].il0, vecs[i].il1, vecs[i].de, vecs[i].dl0, vecs[i].dl1,
            vecs[i].drain);
      step();
      check_all($sformatf("v%0d", i), vecs[i].c0, vecs[i].c1, vecs[i].ovf, vecs[i].unf,
                vecs[i].bn, vecs[i].da);
    end

    // Ramp ch0 from 2 to 958, then cross the almost-full threshold both ways
    for (int i = 0; i < 239; i++) begin
      drive(2'b01, 4, 0, 2'b00, 0, 0, 1'b0);
      step();
    end
    check_all("ramp958", 958, 0, 2'b00, 2'b01, 1'b0, 1'b0);
    drive(2'b01, 1, 0, 2'b00, 0, 0, 1'b0);
    step();
    check_all("af959", 959, 0, 2'b00, 2'b01, 1'b0, 1'b0);
    step();
    check_all("af960", 960, 0, 2'b00, 2'b01, 1'b0, 1'b0);
    drive(2'b00, 0, 0, 2'b01, 1, 0, 1'b0);
    step();
    check_all("af_down959", 959, 0, 2'b00, 2'b01, 1'b0, 1'b0);
    drive(2'b01, 1, 0, 2'b00, 0, 0, 1'b0);
    step();
    check_all("af_up960", 960, 0, 2'b00, 2'b01, 1'b0, 1'b0);

    // Climb past MAX to the top of the counter range, then saturate
    for (int i = 0; i < 271; i++) begin
      drive(2'b01, 4, 0, 2'b00, 0, 0, 1'b0);
      step();
    end
    check_all("ramp2044", 2044, 0, 2'b00, 2'b01, 1'b0, 1'b0);
    drive(2'b01, 3, 0, 2'b00, 0, 0, 1'b0);
    step();
    check_all("top2047", 2047, 0, 2'b00, 2'b01, 1'b0, 1'b0);
    drive(2'b01, 1, 0, 2'b00, 0, 0, 1'b0);
    step();
    check_all("sat1", 2047, 0, 2'b01, 2'b01, 1'b0, 1'b0);
    drive(2'b01, 4, 0, 2'b01, 1, 0, 1'b0);
    step();
    check_all("sat2", 2047, 0, 2'b01, 2'b01, 1'b0, 1'b0);
    drive(2'b00, 0, 0, 2'b01, 4, 0, 1'b0);
    step();
    check_all("down2043", 2043, 0, 2'b01, 2'b01, 1'b0, 1'b0);
    drive(2'b01, 2, 0, 2'b01, 2, 0, 1'b0);
    step();
    check_all("balance", 2043, 0, 2'b01, 2'b01, 1'b0, 1'b0);

    // Enter DRAIN, then hit reset asynchronously between edges
    drive(2'b00, 0, 0, 2'b00, 0, 0, 1'b1);
    step();
    check_all("drain_on", 2043, 0, 2'b01, 2'b01, 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 2'b00, 2'b00, 1'b0, 1'b0);
    drive(2'b00, 0, 0, 2'b00, 0, 0, 1'b0);
    step();
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check_all("post_rst", 0, 0, 2'b00, 2'b00, 1'b0, 1'b0);
    drive(2'b10, 0, 2, 2'b00, 0, 0, 1'b0);
    step();
    check_all("post_rst_cnt", 0, 2, 2'b00, 2'b00, 1'b0, 1'b0);
    drive(2'b00, 0, 0, 2'b00, 0, 0, 1'b1);
    step();
    check_all("post_rst_drain", 0, 2, 2'b00, 2'b00, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
